// File: rtl/cronometro_ctrl_pkg.sv
// Shared types and digit limits for the stopwatch controller and its digit counters.
package cronometro_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned SEC_T_MAX = 5;

  typedef struct packed {
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } time_t;

endpackage

// File: rtl/cronometro_ctrl_if.sv
// Button levels in, display digits and status out; master is the button/display side.
interface cronometro_ctrl_if;

  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic [3:0] sec_u;
  logic [3:0] sec_t;
  logic [3:0] min_u;
  logic       running;
  logic       lap_active;
  logic       tick;
  logic       wrap;

  modport master (
    output btn_start_stop, btn_lap, btn_clear,
    input  sec_u, sec_t, min_u, running, lap_active, tick, wrap
  );

  modport slave (
    input  btn_start_stop, btn_lap, btn_clear,
    output sec_u, sec_t, min_u, running, lap_active, tick, wrap
  );

endinterface

// File: rtl/cronometro_ctrl_digito_bcd.sv
// One BCD digit counting 0..MAX; carry flags the enabled step that rolls it back to 0.
module digito_bcd #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = en && (q == 4'(MAX));

  // NOTE: non-blocking assignment so every chained digit sees the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: button edge detect, start/pause/lap/clear FSM, 1 Hz prescaler, M:SS digit cascade.
module cronometro_ctrl
  import cronometro_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input logic               clk,
  input logic               reset,
  cronometro_ctrl_if.slave  bus
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic             start_q, lap_q, clear_q;
  logic             press_start, press_lap, press_clear;
  logic             running, advance, do_clear, do_latch;
  logic             carry_u, carry_t, carry_m;
  logic [3:0]       live_su, live_st, live_mu;
  time_t            live, lap_time, disp;
  logic             tick, wrap;

  assign press_start = bus.btn_start_stop & ~start_q;
  assign press_lap   = bus.btn_lap        & ~lap_q;
  assign press_clear = bus.btn_clear      & ~clear_q;

  assign running  = (state == RUN) || (state == LAP);
  assign advance  = running && (pre == PRE_LAST);
  assign do_clear = (state == PAUSE) && press_clear;
  // A simultaneous start_stop wins over lap, so no latch then.
  assign do_latch = (state == RUN) && !press_start && press_lap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:  if (press_start) state <= RUN;
        RUN:   if (press_start) state <= PAUSE;
               else if (press_lap) state <= LAP;
        LAP:   if (press_start) state <= PAUSE;
               else if (press_lap) state <= RUN;
        PAUSE: if (press_clear) state <= IDLE;
               else if (press_start) state <= RUN;
      endcase
    end
  end

  // Edge registers load the live levels in reset so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    start_q <= bus.btn_start_stop;
    lap_q   <= bus.btn_lap;
    clear_q <= bus.btn_clear;
  end

  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      pre      <= '0;
      lap_time <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      if (running) pre <= advance ? '0 : pre + 1'b1;
      if (do_latch) lap_time <= live;
      tick <= advance;
      wrap <= carry_m;
    end
  end

  digito_bcd #(.MAX(DIGIT_MAX)) u_sec_u (
    .clk(clk), .reset(reset), .clr(do_clear), .en(advance), .q(live_su), .carry(carry_u)
  );
  digito_bcd #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .reset(reset), .clr(do_clear), .en(carry_u), .q(live_st), .carry(carry_t)
  );
  digito_bcd #(.MAX(DIGIT_MAX)) u_min_u (
    .clk(clk), .reset(reset), .clr(do_clear), .en(carry_t), .q(live_mu), .carry(carry_m)
  );

  assign live = '{min_u: live_mu, sec_t: live_st, sec_u: live_su};
  assign disp = (state == LAP) ? lap_time : live;

  assign bus.sec_u      = disp.sec_u;
  assign bus.sec_t      = disp.sec_t;
  assign bus.min_u      = disp.min_u;
  assign bus.running    = running;
  assign bus.lap_active = (state == LAP);
  assign bus.tick       = tick;
  assign bus.wrap       = wrap;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with TICK_DIV=4: vector table plus wrap and reset sequences.
module tb_cronometro_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_failed = 0;

  always #5 clk = ~clk;

  cronometro_ctrl_if bus ();

  cronometro_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        start;
    logic        lap;
    logic        clear;
    int          cycles;
    logic [11:0] exp_disp;   // {min_u, sec_t, sec_u}
    logic        exp_run;
    logic        exp_lap;
    int          exp_ticks;  // tick pulses seen during the cycles
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n, output int ticks);
    ticks = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.tick === 1'b1) ticks++;
    end
  endtask

  function automatic int disp();
    return int'({bus.min_u, bus.sec_t, bus.sec_u});
  endfunction

  initial begin
    int ticks, ntick, wraps, wrap_tick, orphan, disp599, disp_wrap;

    //        start lap clr cyc  disp     run lap ticks
    vecs[0]  = '{1, 0, 0,  1, 12'h000, 1, 0, 0};  // IDLE -> RUN
    vecs[1]  = '{1, 0, 0,  3, 12'h000, 1, 0, 0};  // held start, pre 1..3
    vecs[2]  = '{0, 0, 0,  1, 12'h001, 1, 0, 1};  // first tick 4 cycles after press
    vecs[3]  = '{0, 0, 0,  1, 12'h001, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 35, 12'h010, 1, 0, 9};  // 10th tick: 0:10
    vecs[5]  = '{0, 0, 0,  1, 12'h010, 1, 0, 0};
    vecs[6]  = '{1, 0, 0,  1, 12'h010, 0, 0, 0};  // pause, pre ends at 2
    vecs[7]  = '{0, 0, 0, 20, 12'h010, 0, 0, 0};  // frozen while paused
    vecs[8]  = '{1, 0, 0,  1, 12'h010, 1, 0, 0};  // resume
    vecs[9]  = '{0, 0, 0,  1, 12'h010, 1, 0, 0};  // pre 2 -> 3
    vecs[10] = '{0, 0, 0,  1, 12'h011, 1, 0, 1};  // partial period kept
    vecs[11] = '{0, 1, 0,  1, 12'h011, 1, 1, 0};  // lap latches 0:11
    vecs[12] = '{0, 1, 0, 12, 12'h011, 1, 1, 3};  // live runs to 0:14, display held
    vecs[13] = '{0, 0, 0,  1, 12'h011, 1, 1, 0};
    vecs[14] = '{0, 1, 0,  1, 12'h014, 1, 0, 0};  // lap again -> live
    vecs[15] = '{0, 0, 1,  1, 12'h015, 1, 0, 1};  // clear ignored in RUN
    vecs[16] = '{1, 0, 0,  1, 12'h015, 0, 0, 0};  // pause
    vecs[17] = '{0, 0, 0,  1, 12'h015, 0, 0, 0};
    vecs[18] = '{1, 0, 1,  1, 12'h000, 0, 0, 0};  // clear beats start in PAUSE
    vecs[19] = '{0, 0, 0,  1, 12'h000, 0, 0, 0};  // stays IDLE
    vecs[20] = '{1, 0, 0,  4, 12'h000, 1, 0, 0};  // prescaler was zeroed by clear
    vecs[21] = '{1, 0, 0,  1, 12'h001, 1, 0, 1};
    vecs[22] = '{0, 1, 0,  1, 12'h001, 1, 1, 0};  // RUN -> LAP
    vecs[23] = '{1, 0, 0,  1, 12'h001, 0, 0, 0};  // LAP -> PAUSE, display live
    vecs[24] = '{0, 0, 0,  5, 12'h001, 0, 0, 0};

    reset = 1'b1;
    bus.btn_start_stop = 1'b0;
    bus.btn_lap        = 1'b0;
    bus.btn_clear      = 1'b0;
    step();
    step();
    check("reset_disp", disp(), 0);
    check("reset_running", int'(bus.running), 0);
    check("reset_lap_active", int'(bus.lap_active), 0);
    check("reset_tick", int'(bus.tick), 0);
    check("reset_wrap", int'(bus.wrap), 0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      bus.btn_start_stop = vecs[i].start;
      bus.btn_lap        = vecs[i].lap;
      bus.btn_clear      = vecs[i].clear;
      step_n(vecs[i].cycles, ticks);
      check($sformatf("v%0d_disp", i), disp(), int'(vecs[i].exp_disp));
      check($sformatf("v%0d_running", i), int'(bus.running), int'(vecs[i].exp_run));
      check($sformatf("v%0d_lap_active", i), int'(bus.lap_active), int'(vecs[i].exp_lap));
      check($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks);
    end

    // Full 600-tick run from 0:00: wrap only on the 600th tick, for one cycle.
    bus.btn_start_stop = 1'b0;
    bus.btn_lap        = 1'b0;
    bus.btn_clear      = 1'b1;
    step();
    bus.btn_clear = 1'b0;
    check("wrap_pre_disp", disp(), 0);
    check("wrap_pre_running", int'(bus.running), 0);
    bus.btn_start_stop = 1'b1;
    step();
    bus.btn_start_stop = 1'b0;
    ntick = 0; wraps = 0; wrap_tick = -1; orphan = 0; disp599 = -1; disp_wrap = -1;
    for (int c = 0; c < 2600 && ntick < 600; c++) begin
      step();
      if (bus.wrap === 1'b1 && bus.tick !== 1'b1) orphan++;
      if (bus.tick === 1'b1) begin
        ntick++;
        if (ntick == 599) disp599 = disp();
      end
      if (bus.wrap === 1'b1) begin
        wraps++;
        wrap_tick = ntick;
        disp_wrap = disp();
      end
    end
    check("wrap_tick_budget", ntick, 600);
    check("wrap_count", wraps, 1);
    check("wrap_at_tick", wrap_tick, 600);
    check("wrap_without_tick", orphan, 0);
    check("disp_at_tick599", disp599, 'h959);
    check("disp_at_wrap", disp_wrap, 0);
    step();
    check("wrap_one_cycle", int'(bus.wrap), 0);
    check("tick_one_cycle", int'(bus.tick), 0);

    // Reset mid-run with start held: no spurious start until the button is re-pressed.
    bus.btn_start_stop = 1'b1;
    reset = 1'b1;
    step();
    check("rst6_disp", disp(), 0);
    check("rst6_running", int'(bus.running), 0);
    check("rst6_lap_active", int'(bus.lap_active), 0);
    check("rst6_tick", int'(bus.tick), 0);
    check("rst6_wrap", int'(bus.wrap), 0);
    reset = 1'b0;
    step_n(5, ticks);
    check("rst6_held_running", int'(bus.running), 0);
    check("rst6_held_ticks", ticks, 0);
    bus.btn_start_stop = 1'b0;
    step();
    bus.btn_start_stop = 1'b1;
    step();
    check("rst6_repress_running", int'(bus.running), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
